// File: rtl/mulacc_dot_seq_if.sv
// mulacc_dot_seq_if: command, operand, CFU request/response and result bundle of the dot-product sequencer
interface mulacc_dot_seq_if #(
    parameter int CFU_FUNC_ID_W   = 5,
    parameter int CFU_REQ_DATA_W  = 32,
    parameter int CFU_RESP_DATA_W = 32,
    parameter int LEN_W           = 16
) ();
    logic                       cmd_valid;
    logic                       cmd_ready;
    logic [LEN_W-1:0]           cmd_len;
    logic                       op_valid;
    logic                       op_ready;
    logic [CFU_REQ_DATA_W-1:0]  op_data0;
    logic [CFU_REQ_DATA_W-1:0]  op_data1;
    logic                       req_valid;
    logic [CFU_FUNC_ID_W-1:0]   req_func_id;
    logic [CFU_REQ_DATA_W-1:0]  req_data0;
    logic [CFU_REQ_DATA_W-1:0]  req_data1;
    logic                       resp_valid;
    logic [CFU_RESP_DATA_W-1:0] resp_data;
    logic                       resp_err;
    logic                       res_valid;
    logic                       res_ready;
    logic [CFU_RESP_DATA_W-1:0] res_data;
    logic                       res_err;

    modport slave (
        input  cmd_valid, cmd_len, op_valid, op_data0, op_data1,
               resp_valid, resp_data, resp_err, res_ready,
        output cmd_ready, op_ready, req_valid, req_func_id, req_data0, req_data1,
               res_valid, res_data, res_err
    );

    modport master (
        output cmd_valid, cmd_len, op_valid, op_data0, op_data1,
               resp_valid, resp_data, resp_err, res_ready,
        input  cmd_ready, op_ready, req_valid, req_func_id, req_data0, req_data1,
               res_valid, res_data, res_err
    );
endinterface

// File: rtl/mulacc_dot_seq.sv
// mulacc_dot_seq: sequences clear + N mul-acc requests to a fixed-latency CFU and returns the final accumulator
module mulacc_dot_seq #(
    parameter int CFU_FUNC_ID_W    = 5,
    parameter int CFU_REQ_DATA_W   = 32,
    parameter int CFU_RESP_DATA_W  = 32,
    parameter int CFU_RESP_LATENCY = 3,
    parameter int LEN_W            = 16
) (
    input logic            clk,
    input logic            rst,
    mulacc_dot_seq_if.slave bus
);
    localparam logic [2:0] IDLE   = 3'd0;
    localparam logic [2:0] CLEAR  = 3'd1;
    localparam logic [2:0] STREAM = 3'd2;
    localparam logic [2:0] DRAIN  = 3'd3;
    localparam logic [2:0] DONE   = 3'd4;

    logic [2:0]                 state;
    logic [LEN_W-1:0]           n_len;
    logic [LEN_W-1:0]           remaining;
    logic [LEN_W:0]             resp_cnt;
    logic [LEN_W:0]             cnt_nxt;
    logic                       track;
    logic                       req_valid;
    logic [CFU_FUNC_ID_W-1:0]   req_func_id;
    logic [CFU_REQ_DATA_W-1:0]  req_data0;
    logic [CFU_REQ_DATA_W-1:0]  req_data1;
    logic [CFU_RESP_DATA_W-1:0] res_data;
    logic                       res_err;

    assign track   = state != IDLE && state != DONE;
    assign cnt_nxt = resp_cnt + {{LEN_W{1'b0}}, bus.resp_valid};

    assign bus.cmd_ready   = state == IDLE;
    assign bus.op_ready    = state == STREAM;
    assign bus.res_valid   = state == DONE;
    assign bus.req_valid   = req_valid;
    assign bus.req_func_id = req_func_id;
    assign bus.req_data0   = req_data0;
    assign bus.req_data1   = req_data1;
    assign bus.res_data    = res_data;
    assign bus.res_err     = res_err;

    // sequencer FSM, single-cycle request pulses and response accumulation (DONE needs all N+1 responses)
    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= IDLE;
            n_len       <= '0;
            remaining   <= '0;
            resp_cnt    <= '0;
            req_valid   <= 1'b0;
            req_func_id <= '0;
            req_data0   <= '0;
            req_data1   <= '0;
            res_data    <= '0;
            res_err     <= 1'b0;
        end else begin
            req_valid <= 1'b0;
            if (track && bus.resp_valid) begin
                resp_cnt <= cnt_nxt;
                res_data <= bus.resp_data;
                res_err  <= res_err | bus.resp_err;
            end
            case (state)
                IDLE: if (bus.cmd_valid) begin
                    n_len     <= bus.cmd_len;
                    remaining <= bus.cmd_len;
                    resp_cnt  <= '0;
                    res_err   <= 1'b0;
                    state     <= CLEAR;
                end
                CLEAR: begin
                    req_valid   <= 1'b1;
                    req_func_id <= '0;
                    req_data0   <= '0;
                    req_data1   <= '0;
                    state       <= n_len == '0 ? DRAIN : STREAM;
                end
                STREAM: if (bus.op_valid) begin
                    req_valid   <= 1'b1;
                    req_func_id <= CFU_FUNC_ID_W'(1);
                    req_data0   <= bus.op_data0;
                    req_data1   <= bus.op_data1;
                    remaining   <= remaining - LEN_W'(1);
                    if (remaining == LEN_W'(1)) state <= DRAIN;
                end
                DRAIN: if (bus.resp_valid && cnt_nxt == {1'b0, n_len} + (LEN_W+1)'(1)) state <= DONE;
                DONE: if (bus.res_ready) state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_mulacc_dot_seq.sv
// tb_mulacc_dot_seq: randomized scoreboard bench with a fixed-latency CFU model and a dot-product reference
module tb_mulacc_dot_seq;
    localparam int L = 3;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;

    mulacc_dot_seq_if bus ();

    mulacc_dot_seq dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // CFU model: clear/mul-acc with L register stages, error flag injected on response index err_at
    logic [L-1:0] sv;
    logic [L-1:0] se;
    logic [31:0]  sd [L];
    logic [31:0]  cfu_acc;
    logic [31:0]  nacc;
    int           cfu_idx;
    int           cidx;
    int           err_at = -1;

    always @(posedge clk) begin
        if (rst) begin
            sv      <= '0;
            se      <= '0;
            cfu_acc <= '0;
            cfu_idx <= 0;
        end else begin
            nacc = bus.req_func_id == 0 ? 32'd0 : cfu_acc + bus.req_data0 * bus.req_data1;
            cidx = bus.req_func_id == 0 ? 0 : cfu_idx;
            sv <= {sv[L-2:0], bus.req_valid};
            se <= {se[L-2:0], bus.req_valid && cidx == err_at};
            sd[0] <= nacc;
            for (int i = 1; i < L; i++) sd[i] <= sd[i-1];
            if (bus.req_valid) begin
                cfu_acc <= nacc;
                cfu_idx <= cidx + 1;
            end
        end
    end

    assign bus.resp_valid = sv[L-1];
    assign bus.resp_data  = sd[L-1];
    assign bus.resp_err   = se[L-1];

    // scoreboard: {err, data} expected per command
    logic [32:0] exp_q [$];

    always @(negedge clk) begin
        if (!rst && bus.res_valid && bus.res_ready) begin
            if (exp_q.size() == 0) chk("res_unexpected", bus.res_valid, 0);
            else begin
                logic [32:0] e;
                e = exp_q.pop_front();
                chk("res_data", bus.res_data, e[31:0]);
                chk("res_err", bus.res_err, e[32]);
            end
        end
    end

    // request monitor: counts pulses and flags a mul-acc pulse not preceded by an operand handshake
    int reqs = 0;
    int gap_bad = 0;
    int last_func = -1;
    bit prev_hs = 0;

    always @(negedge clk) begin
        if (rst) prev_hs = 0;
        else begin
            if (bus.req_valid) begin
                reqs++;
                last_func = bus.req_func_id;
                if (bus.req_func_id == 1 && !prev_hs) gap_bad++;
            end
            prev_hs = bus.op_valid && bus.op_ready;
        end
    end

    logic [31:0] pa [0:127];
    logic [31:0] pb [0:127];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // mode: 0 op_valid held, 1 toggling, 2 random; hold: cycles res_ready stays low after res_valid
    task automatic do_cmd(input int n, input int mode, input int hold, input int ea);
        logic [31:0] sum;
        int t0, k, i, r0, g0;
        bit tog, hs, ok;
        logic [31:0] d0;
        logic e0;
        sum = 0;
        for (int j = 0; j < n; j++) sum += pa[j] * pb[j];
        exp_q.push_back({ea >= 0 && ea <= n, sum});
        err_at = ea;
        bus.res_ready = hold == 0;
        r0 = reqs;
        g0 = gap_bad;
        bus.cmd_valid = 1;
        bus.cmd_len = 16'(n);
        k = 0;
        while (!bus.cmd_ready && k < 200) begin step(); k++; end
        chk("cmd_hs", bus.cmd_ready, 1);
        step();
        t0 = cyc;
        bus.cmd_valid = 0;
        tog = 1;
        i = 0;
        k = 0;
        while (i < n && k < 5000) begin
            bus.op_valid = mode == 0 ? 1'b1 : mode == 1 ? tog : 1'($urandom % 2);
            bus.op_data0 = pa[i];
            bus.op_data1 = pb[i];
            hs = bus.op_valid && bus.op_ready;
            step();
            tog = ~tog;
            k++;
            if (hs) i++;
        end
        bus.op_valid = 0;
        chk("ops_sent", i, n);
        k = 0;
        while (!bus.res_valid && k < 500) begin step(); k++; end
        chk("res_rise", bus.res_valid, 1);
        if (mode == 0) chk("latency", cyc - t0, n + L + 2);
        if (hold > 0) begin
            d0 = bus.res_data;
            e0 = bus.res_err;
            ok = 1;
            for (int j = 0; j < hold; j++) begin
                step();
                ok &= bus.res_valid && bus.res_data == d0 && bus.res_err == e0 && !bus.cmd_ready;
            end
            chk("res_stable", ok, 1);
            bus.res_ready = 1;
        end
        step();
        chk("res_cleared", bus.res_valid, 0);
        chk("req_pulses", reqs - r0, n + 1);
        chk("req_gap", gap_bad - g0, 0);
    endtask

    initial begin
        bus.cmd_valid = 0;
        bus.cmd_len = 0;
        bus.op_valid = 0;
        bus.op_data0 = 0;
        bus.op_data1 = 0;
        bus.res_ready = 1;
        step();
        step();
        rst = 0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_op_ready", bus.op_ready, 0);
        chk("rst_req_valid", bus.req_valid, 0);
        chk("rst_req_func", bus.req_func_id, 0);
        chk("rst_req_data0", bus.req_data0, 0);
        chk("rst_req_data1", bus.req_data1, 0);
        chk("rst_res_valid", bus.res_valid, 0);
        chk("rst_res_data", bus.res_data, 0);
        chk("rst_res_err", bus.res_err, 0);

        for (int k = 0; k < 100; k++) begin pa[k] = 1; pb[k] = k + 1; end
        do_cmd(100, 0, 0, -1);

        do_cmd(0, 0, 0, -1);
        chk("n0_func", last_func, 0);

        for (int k = 0; k < 8; k++) begin pa[k] = k + 1; pb[k] = k + 2; end
        do_cmd(8, 1, 0, -1);

        for (int k = 0; k < 5; k++) begin pa[k] = $urandom; pb[k] = $urandom; end
        do_cmd(5, 0, 20, -1);

        for (int k = 0; k < 4; k++) begin pa[k] = k + 3; pb[k] = 7; end
        do_cmd(4, 0, 0, 2);
        do_cmd(4, 0, 0, -1);

        for (int k = 0; k < 10; k++) begin pa[k] = k + 1; pb[k] = 5; end
        bus.cmd_valid = 1;
        bus.cmd_len = 10;
        step();
        bus.cmd_valid = 0;
        bus.op_valid = 1;
        for (int k = 0; k < 4; k++) begin
            bus.op_data0 = pa[k];
            bus.op_data1 = pb[k];
            step();
        end
        bus.op_valid = 0;
        rst = 1;
        step();
        rst = 0;
        chk("mid_rst_cmd_ready", bus.cmd_ready, 1);
        chk("mid_rst_op_ready", bus.op_ready, 0);
        chk("mid_rst_req_valid", bus.req_valid, 0);
        chk("mid_rst_res_valid", bus.res_valid, 0);
        for (int k = 0; k < 3; k++) begin pa[k] = 2; pb[k] = 3; end
        do_cmd(3, 0, 0, -1);

        for (int t = 0; t < 8; t++) begin
            int n;
            n = $urandom_range(1, 12);
            for (int k = 0; k < n; k++) begin pa[k] = $urandom; pb[k] = $urandom; end
            do_cmd(n, 2, $urandom_range(0, 4), ($urandom % 3 == 0) ? $urandom_range(0, n) : -1);
        end

        step();
        chk("scoreboard_empty", exp_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
